// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared defaults and the helper that sizes the table-select port
`default_nettype none

package lut_neuron_pkg;

  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_FANIN_BITS  = 8;
  localparam int DEF_OUT_BITS    = 1;

  // A single neuron still needs a one-bit select so the port never collapses to zero width.
  function automatic int neuron_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_neuron_table.sv
// lut_neuron_table: one neuron's truth table with its write decode and a combinational read
`default_nettype none

module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int FANIN_BITS = DEF_FANIN_BITS,
  parameter int OUT_BITS   = DEF_OUT_BITS,
  parameter int SEL_W      = 1,
  parameter int NEURON_IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_neuron,
  input  logic [FANIN_BITS-1:0] cfg_addr,
  input  logic [OUT_BITS-1:0]   cfg_data,
  input  logic [FANIN_BITS-1:0] rd_addr,
  output logic [OUT_BITS-1:0]   rd_data
);

  localparam int DEPTH = 1 << FANIN_BITS;

  logic [OUT_BITS-1:0] mem_q [DEPTH];
  logic [OUT_BITS-1:0] mem_d [DEPTH];
  logic                wr_hit;

  // Selectors at or beyond the neuron count match no instance, so such writes vanish.
  always_comb begin
    wr_hit = cfg_we && (int'(cfg_neuron) == NEURON_IDX);
    mem_d  = mem_q;
    if (wr_hit) begin
      mem_d[cfg_addr] = cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-write contents during a write edge.
  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/lut_neuron_layer_pipe.sv
// lut_neuron_layer_pipe: NUM_NEURONS truth-table neurons behind a two-stage valid/ready pipeline
`default_nettype none

module lut_neuron_layer_pipe
  import lut_neuron_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int FANIN_BITS  = DEF_FANIN_BITS,
  parameter int OUT_BITS    = DEF_OUT_BITS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_NEURONS*FANIN_BITS-1:0]      in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0]        out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  input  logic                                   cfg_we,
  input  logic [neuron_sel_w(NUM_NEURONS)-1:0]   cfg_neuron,
  input  logic [FANIN_BITS-1:0]                  cfg_addr,
  input  logic [OUT_BITS-1:0]                    cfg_data
);

  localparam int SEL_W = neuron_sel_w(NUM_NEURONS);
  localparam int AW    = NUM_NEURONS * FANIN_BITS;
  localparam int DW    = NUM_NEURONS * OUT_BITS;

  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [DW-1:0] lookup;
  logic          s2_adv, s1_adv;

  generate
    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
      lut_neuron_table #(
        .FANIN_BITS (FANIN_BITS),
        .OUT_BITS   (OUT_BITS),
        .SEL_W      (SEL_W),
        .NEURON_IDX (i)
      ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .rd_addr    (s1_addr_q[i*FANIN_BITS +: FANIN_BITS]),
        .rd_data    (lookup[i*OUT_BITS +: OUT_BITS])
      );
    end
  endgenerate

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lookup;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_addr_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lut_neuron_layer_pipe.sv
// tb_lut_neuron_layer_pipe: scoreboard bench with a table-array reference model
`timescale 1ns/1ps
`default_nettype none

module tb_lut_neuron_layer_pipe;

  // Three neurons so that a selector equal to the neuron count is encodable on the port.
  localparam int NN    = 3;
  localparam int FB    = 8;
  localparam int OB    = 1;
  localparam int SW    = 2;
  localparam int AW    = NN * FB;
  localparam int DW    = NN * OB;
  localparam int DEPTH = 1 << FB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_neuron = '0;
  logic [FB-1:0] cfg_addr = '0;
  logic [OB-1:0] cfg_data = '0;

  lut_neuron_layer_pipe #(
    .NUM_NEURONS (NN),
    .FANIN_BITS  (FB),
    .OUT_BITS    (OB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [OB-1:0] model_tbl [NN][DEPTH];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            acc_cnt = 0;
  int            pop_cnt = 0;
  bit            lat_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_lookup(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NN; i++) begin
      r[i*OB +: OB] = model_tbl[i][a[i*FB +: FB]];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++)
        model_tbl[n][a] = '0;
  endtask

  // Acceptance side: the expected result is fixed by the table contents when the input is taken.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back('{data: model_lookup(in_data), cyc: cyc});
      acc_cnt++;
    end
  end

  // Output side: every transfer pops one expectation; stalls must hold valid and data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected no transfer (t=%0t)", out_data, $time);
        end else begin
          e = sb_q.pop_front();
          pop_cnt++;
          check("out_data", out_data, e.data);
          if (lat_en) check("latency", cyc - e.cyc, 2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    cfg_we     = 1'b1;
    cfg_neuron = n[SW-1:0];
    cfg_addr   = a[FB-1:0];
    cfg_data   = d[OB-1:0];
    tick();
    cfg_we = 1'b0;
    if (n < NN) model_tbl[n][a] = d[OB-1:0];
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    sb_q.delete();
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, (n < 200), 1);
  endtask

  task automatic set_all_slices(input logic [FB-1:0] a);
    for (int i = 0; i < NN; i++) in_data[i*FB +: FB] = a;
  endtask

  task automatic stream_all(input string tag);
    int start;
    start     = pop_cnt;
    out_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1;
      set_all_slices(a[FB-1:0]);
      tick();
    end
    drain(tag);
    check({tag, "_count"}, pop_cnt - start, DEPTH);
  endtask

  initial begin
    int saved;
    model_clear();
    tick();
    do_reset();

    // Single hot entry: 0x80 then 0x00 through neuron 0.
    cfg_write(0, 'h80, 1);
    lat_en    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    in_data[FB-1:0] = 8'h80;
    tick();
    in_data = '0;
    tick();
    drain("hot_entry");
    lat_en = 1'b0;

    // Write coinciding with the S1->S2 lookup of the same entry.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_all_slices(8'h05);
    tick();
    in_valid = 1'b0;
    cfg_write(1, 'h05, 1);
    in_valid = 1'b1;
    tick();
    drain("wr_collide");

    // Parity tables, full back-to-back stream.
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++)
        cfg_write(n, a, int'(^a[FB-1:0]));
    lat_en = 1'b1;
    stream_all("parity");
    lat_en = 1'b0;

    // Output stalled for five cycles with input offered.
    acc_cnt   = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = AW'($urandom);
      tick();
    end
    check("stall_accepts", acc_cnt, 2);
    check("stall_in_ready", in_ready, 0);
    drain("stall");

    // Random tables, random traffic and back-pressure.
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++)
        cfg_write(n, a, int'($urandom_range(0, 1)));
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = AW'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain("random");

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_all_slices(8'h3C);
    tick();
    set_all_slices(8'hC3);
    tick();
    check("inflight_valid", out_valid, 1);
    saved = pop_cnt;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("no_out_after_rst", pop_cnt, saved);
    stream_all("rst_readback");

    // Out-of-range selector writes must leave every table untouched.
    cfg_write(NN, 'h00, 1);
    cfg_write(NN, 'h05, 1);
    cfg_write(NN, 'h80, 1);
    cfg_write(NN, 'hFF, 1);
    for (int k = 0; k < 8; k++) cfg_write(NN, int'($urandom_range(0, DEPTH - 1)), 1);
    stream_all("oob_readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
